// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int TIME_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle between a pulse train client and the generator.
// Handshake: start is a valid strobe, ~busy is ready; start is accepted only in a cycle with busy=0.
interface pulse_train_gen_if
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
);

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_pulses;
  logic [TIME_W-1:0] high_cycles;
  logic [TIME_W-1:0] low_cycles;
  logic              pulse_out;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, num_pulses, high_cycles, low_cycles,
    input  pulse_out, busy, done
  );

  modport slave (
    input  start, abort, num_pulses, high_cycles, low_cycles,
    output pulse_out, busy, done
  );

endinterface

// File: rtl/pulse_train_gen_cycle_timer.sv
// Loadable down-counter; tc_o flags the last cycle of a loaded duration.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Loading V gives V cycles with cnt_q = V..1; tc_o marks the one with cnt_q = 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: a start strobe launches N high pulses of H cycles separated by L low cycles.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pulse_train_gen_if.slave   bus,
  output state_e             state_o
);

  state_e            state_q;
  logic [CNT_W-1:0]  rem_q;
  logic [TIME_W-1:0] cfg_high_q, cfg_low_q;
  logic              pulse_q, busy_q, done_q;

  logic              tmr_load_d;
  logic [TIME_W-1:0] tmr_val_d;
  logic              tmr_tc;
  logic [TIME_W-1:0] high_eff, low_eff;

  assign high_eff = (bus.high_cycles == '0) ? TIME_W'(1) : bus.high_cycles;
  assign low_eff  = (bus.low_cycles  == '0) ? TIME_W'(1) : bus.low_cycles;

  // Timer reloads at train start and at every phase boundary; abort suppresses reloads.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = cfg_high_q;
    case (state_q)
      IDLE: if (bus.start && bus.num_pulses != '0) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = high_eff;
      end
      HIGH: if (!bus.abort && tmr_tc && rem_q > CNT_W'(1)) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = cfg_low_q;
      end
      LOW: if (!bus.abort && tmr_tc) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = cfg_high_q;
      end
      default: ;
    endcase
  end

  cycle_timer #(.W(TIME_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load_d),
    .val_i  (tmr_val_d),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cfg_high_q <= '0;
      cfg_low_q  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_pulses != '0) begin
              state_q    <= HIGH;
              rem_q      <= bus.num_pulses;
              cfg_high_q <= high_eff;
              cfg_low_q  <= low_eff;
              pulse_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (bus.abort) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tmr_tc) begin
            pulse_q <= 1'b0;
            if (rem_q > CNT_W'(1)) begin
              state_q <= LOW;
              rem_q   <= rem_q - CNT_W'(1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        LOW: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tmr_tc) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_o       = state_q;

endmodule
